jtkcpu_memseq: RTL

JTKCPU_MEMSEQ -- requirements
Module: jtkcpu_memseq

---
 rtl/jtkcpu_memseq_if.sv | 42 ++++
 rtl/jtkcpu_memseq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_memseq_if.sv
// Request and byte-bus bundle for the KCPU memory sequencer.
// The master side issues requests and answers bus cycles; the slave side is the sequencer.
interface jtkcpu_memseq_if;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic        rd_16;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_16;
    logic        stk_req;
    logic [15:0] stk_addr;
    logic        stk_wr;
    logic [7:0]  stk_data;
    logic [15:0] bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;
    logic        bus_ok;
    logic [15:0] mdata;
    logic        mem_busy;
    logic        done;
    logic [1:0]  grant;
    logic        buserror;

    modport master (
        output fetch_req, fetch_addr, rd_req, rd_addr, rd_16,
               wr_req, wr_addr, wr_data, wr_16,
               stk_req, stk_addr, stk_wr, stk_data, bus_din, bus_ok,
        input  bus_addr, bus_rd, bus_wr, bus_dout, mdata, mem_busy, done, grant, buserror
    );

    modport slave (
        input  fetch_req, fetch_addr, rd_req, rd_addr, rd_16,
               wr_req, wr_addr, wr_data, wr_16,
               stk_req, stk_addr, stk_wr, stk_data, bus_din, bus_ok,
        output bus_addr, bus_rd, bus_wr, bus_dout, mdata, mem_busy, done, grant, buserror
    );
endinterface

// File: rtl/jtkcpu_memseq.sv
// KCPU memory sequencer: arbitrates fetch/rd/wr/stack requests onto an 8-bit
// bus, splitting 16-bit accesses into two big-endian byte cycles.
module jtkcpu_memseq (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    jtkcpu_memseq_if.slave   bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_BYTE1, ST_BYTE2} state_t;

    state_t      r_state,    w_state;
    logic [15:0] r_addr,     w_addr;
    logic [15:0] r_data,     w_data;
    logic        r_is16,     w_is16;
    logic        r_wr,       w_wr;
    logic [7:0]  r_wait,     w_wait;
    logic [15:0] r_bus_addr, w_bus_addr;
    logic        r_bus_rd,   w_bus_rd;
    logic        r_bus_wr,   w_bus_wr;
    logic [7:0]  r_bus_dout, w_bus_dout;
    logic [15:0] r_mdata,    w_mdata;
    logic        r_busy,     w_busy;
    logic        r_done,     w_done;
    logic [1:0]  r_grant,    w_grant;
    logic        r_buserr,   w_buserr;

    // Winning request, fixed priority wr > stk > rd > fetch
    logic        w_req_valid;
    logic [1:0]  w_req_grant;
    logic [15:0] w_req_addr;
    logic [15:0] w_req_data;
    logic        w_req_is16;
    logic        w_req_wr;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_req_valid = 1'b1;
        w_req_grant = 2'd0;
        w_req_addr  = bus.fetch_addr;
        w_req_data  = 16'h0000;
        w_req_is16  = 1'b0;
        w_req_wr    = 1'b0;
        if (bus.wr_req) begin
            w_req_grant = 2'd2;
            w_req_addr  = bus.wr_addr;
            w_req_data  = bus.wr_16 ? bus.wr_data : {8'h00, bus.wr_data[7:0]};
            w_req_is16  = bus.wr_16;
            w_req_wr    = 1'b1;
        end else if (bus.stk_req) begin
            w_req_grant = 2'd3;
            w_req_addr  = bus.stk_addr;
            w_req_data  = {8'h00, bus.stk_data};
            w_req_wr    = bus.stk_wr;
        end else if (bus.rd_req) begin
            w_req_grant = 2'd1;
            w_req_addr  = bus.rd_addr;
            w_req_is16  = bus.rd_16;
        end else if (!bus.fetch_req) begin
            w_req_valid = 1'b0;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_addr     = r_addr;
        w_data     = r_data;
        w_is16     = r_is16;
        w_wr       = r_wr;
        w_wait     = r_wait;
        w_bus_addr = r_bus_addr;
        w_bus_rd   = r_bus_rd;
        w_bus_wr   = r_bus_wr;
        w_bus_dout = r_bus_dout;
        w_mdata    = r_mdata;
        w_busy     = r_busy;
        w_grant    = r_grant;
        w_done     = 1'b0;
        w_buserr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // The cycle right after done never grants, giving other requesters a look-in
                if (!r_done && w_req_valid) begin
                    w_state    = ST_BYTE1;
                    w_addr     = w_req_addr;
                    w_data     = w_req_data;
                    w_is16     = w_req_is16;
                    w_wr       = w_req_wr;
                    w_grant    = w_req_grant;
                    w_busy     = 1'b1;
                    w_wait     = 8'd0;
                    w_bus_addr = w_req_addr;
                    w_bus_rd   = !w_req_wr;
                    w_bus_wr   = w_req_wr;
                    w_bus_dout = w_req_is16 ? w_req_data[15:8] : w_req_data[7:0];
                end
            end
            ST_BYTE1, ST_BYTE2: begin
                if (bus.bus_ok) begin
                    if (!r_wr) begin
                        if (!r_is16)
                            w_mdata = {8'h00, bus.bus_din};
                        else if (r_state == ST_BYTE1)
                            w_mdata[15:8] = bus.bus_din;
                        else
                            w_mdata[7:0] = bus.bus_din;
                    end
                    if (r_state == ST_BYTE1 && r_is16) begin
                        w_state    = ST_BYTE2;
                        w_wait     = 8'd0;
                        w_bus_addr = r_addr + 16'd1;
                        w_bus_dout = r_data[7:0];
                    end else begin
                        w_state  = ST_IDLE;
                        w_bus_rd = 1'b0;
                        w_bus_wr = 1'b0;
                        w_busy   = 1'b0;
                        w_done   = 1'b1;
                    end
                end else if (r_wait == 8'hFF) begin
                    // Abort only once the counter already shows 255 low cycles
                    w_state  = ST_IDLE;
                    w_bus_rd = 1'b0;
                    w_bus_wr = 1'b0;
                    w_busy   = 1'b0;
                    w_buserr = 1'b1;
                end else begin
                    w_wait = r_wait + 8'd1;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all updates land together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= 16'h0000;
            r_data     <= 16'h0000;
            r_is16     <= 1'b0;
            r_wr       <= 1'b0;
            r_wait     <= 8'd0;
            r_bus_addr <= 16'h0000;
            r_bus_rd   <= 1'b0;
            r_bus_wr   <= 1'b0;
            r_bus_dout <= 8'h00;
            r_mdata    <= 16'h0000;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_grant    <= 2'd0;
            r_buserr   <= 1'b0;
        end else if (cen) begin
            r_state    <= w_state;
            r_addr     <= w_addr;
            r_data     <= w_data;
            r_is16     <= w_is16;
            r_wr       <= w_wr;
            r_wait     <= w_wait;
            r_bus_addr <= w_bus_addr;
            r_bus_rd   <= w_bus_rd;
            r_bus_wr   <= w_bus_wr;
            r_bus_dout <= w_bus_dout;
            r_mdata    <= w_mdata;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_grant    <= w_grant;
            r_buserr   <= w_buserr;
        end
    end

    assign bus.bus_addr = r_bus_addr;
    assign bus.bus_rd   = r_bus_rd;
    assign bus.bus_wr   = r_bus_wr;
    assign bus.bus_dout = r_bus_dout;
    assign bus.mdata    = r_mdata;
    assign bus.mem_busy = r_busy;
    assign bus.done     = r_done;
    assign bus.grant    = r_grant;
    assign bus.buserror = r_buserr;
endmodule
